// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read, a single-entry hold
// register toward the decoder, and redirect handling that discards stale data.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic            issue_c;

    // imem_req is low in the first REQ cycle after reset, so a gnt there is not a handshake
    assign issue_c   = imem_req && imem_gnt;
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        case (state)
            REQ:  if (issue_c) state_nxt = redirect ? DROP : WAIT;
            WAIT: begin
                if (imem_rvalid)   state_nxt = redirect ? REQ : HOLD;
                else if (redirect) state_nxt = DROP;
            end
            HOLD: if (redirect || inst_ready) state_nxt = REQ;
            DROP: if (imem_rvalid) state_nxt = REQ;
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
            inst        <= NOP;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == REQ);
            if (redirect) begin
                pc         <= {redirect_pc[XLEN-1:2], 2'b00};
                inst_valid <= 1'b0;
            end else begin
                if (state == WAIT && imem_rvalid) begin
                    inst       <= imem_rdata;
                    inst_pc    <= pc;
                    inst_valid <= 1'b1;
                    pc         <= pc + XLEN'(4);
                end
                if (state == HOLD && inst_ready) begin
                    inst_valid  <= 1'b0;
                    fetch_count <= fetch_count + XLEN'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table for the documented scenarios,
// then randomized traffic against a transaction-level fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_bad = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, gnt, rv;
        logic [31:0] rdata;
        bit          rdy, rd;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_val;
        logic [31:0] e_inst, e_ipc, e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input bit e_req, input logic [31:0] e_addr,
                         input bit e_val, input logic [31:0] e_inst, input logic [31:0] e_ipc,
                         input logic [31:0] e_cnt);
        n_vec++;
        if (imem_req !== e_req || imem_addr !== e_addr || inst_valid !== e_val ||
            inst !== e_inst || inst_pc !== e_ipc || fetch_count !== e_cnt) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h val=%0b inst=%h pc=%h cnt=%0d, want req=%0b addr=%h val=%0b inst=%h pc=%h cnt=%0d",
                     name, imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_count,
                     e_req, e_addr, e_val, e_inst, e_ipc, e_cnt);
        end
    endtask

    task automatic drive(input bit r, input bit g, input bit v, input logic [31:0] d,
                         input bit y, input bit rd, input logic [31:0] rp);
        rst = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        inst_ready = y; redirect = rd; redirect_pc = rp;
    endtask

    // Fetch model: tracks outstanding request, discard flag and decoder slot
    bit          m_req, m_out, m_drop, m_have;
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;

    task automatic model_step();
        bit issue, ret;
        issue = m_req && imem_gnt;
        ret   = m_out && imem_rvalid;
        if (rst) begin
            m_pc = 32'h0; m_out = 0; m_drop = 0; m_have = 0;
            m_inst = 32'h13; m_ipc = 0; m_cnt = 0; m_req = 0;
            return;
        end
        if (redirect) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            m_have = 0;
            if (ret) begin m_out = 0; m_drop = 0; end
            else if (m_out) m_drop = 1;
            if (issue) begin m_out = 1; m_drop = 1; end
        end else begin
            if (issue) begin m_out = 1; m_drop = 0; end
            if (ret) begin
                m_out = 0;
                if (!m_drop) begin
                    m_inst = imem_rdata; m_ipc = m_pc; m_have = 1; m_pc = m_pc + 32'd4;
                end
                m_drop = 0;
            end else if (m_have && inst_ready) begin
                m_have = 0; m_cnt = m_cnt + 32'd1;
            end
        end
        m_req = !m_out && !m_have;
    endtask

    initial begin
        // rst gnt rv rdata rdy rd rpc | req addr val inst ipc cnt
        vecs.push_back('{1,0,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{1,1,1,32'h9,1,0,32'h0,         0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,0,0,32'h0,0,0,32'h0,         1,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,0,1,32'h00500093,1,0,32'h0,  0,32'h4,1,32'h00500093,32'h0,0});
        vecs.push_back('{0,0,0,32'h0,1,0,32'h0,         1,32'h4,0,32'h00500093,32'h0,1});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{0,0,0,32'h0,0,0,32'h0,     1,32'h4,0,32'h00500093,32'h0,1});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h4,0,32'h00500093,32'h0,1});
        vecs.push_back('{0,0,1,32'h11111111,0,0,32'h0,  0,32'h8,1,32'h11111111,32'h4,1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{0,0,i[0],32'hABCD0000,0,0,32'h0, 0,32'h8,1,32'h11111111,32'h4,1});
        vecs.push_back('{0,0,0,32'h0,1,0,32'h0,         1,32'h8,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h8,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,0,0,32'h0,0,1,32'h103,       0,32'h100,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,0,1,32'hDEADBEEF,0,0,32'h0,  1,32'h100,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,1,0,32'h0,0,1,32'h200,       0,32'h200,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,0,1,32'hBAD0BAD0,0,0,32'h0,  1,32'h200,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h200,0,32'h11111111,32'h4,2});
        vecs.push_back('{0,0,1,32'h22222222,0,0,32'h0,  0,32'h204,1,32'h22222222,32'h200,2});
        vecs.push_back('{0,0,0,32'h0,1,1,32'hFFFFFFFE,  1,32'hFFFFFFFC,0,32'h22222222,32'h200,2});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'hFFFFFFFC,0,32'h22222222,32'h200,2});
        vecs.push_back('{0,0,1,32'h33333333,0,0,32'h0,  0,32'h0,1,32'h33333333,32'hFFFFFFFC,2});
        vecs.push_back('{0,0,0,32'h0,1,0,32'h0,         1,32'h0,0,32'h33333333,32'hFFFFFFFC,3});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h33333333,32'hFFFFFFFC,3});
        vecs.push_back('{0,0,1,32'h44444444,0,1,32'h40, 1,32'h40,0,32'h33333333,32'hFFFFFFFC,3});
        vecs.push_back('{0,0,1,32'h0,0,1,32'h81,        1,32'h80,0,32'h33333333,32'hFFFFFFFC,3});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h80,0,32'h33333333,32'hFFFFFFFC,3});
        vecs.push_back('{1,0,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{1,0,1,32'h55555555,1,0,32'h0,  0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,0,1,32'h77777777,0,0,32'h0,  1,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,1,0,32'h0,0,0,32'h0,         0,32'h0,0,32'h13,32'h0,0});
        vecs.push_back('{0,0,1,32'h66666666,0,0,32'h0,  0,32'h4,1,32'h66666666,32'h0,0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
                  vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_cnt);
        end

        // randomized traffic, model resynchronised by a reset cycle
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int c = 0; c < 4000; c++) begin
            if (c != 0) begin
                drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 9) < 4), $urandom(), ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 11) == 0),
                      ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC | 32'($urandom_range(0, 3))
                                                  : $urandom());
            end
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand%0d", c), m_req, m_pc, m_have, m_inst, m_ipc, m_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
